// File: rtl/registro_indicadores_pkg.sv
// Shared constants for the status-flag register: condition codes, flag bit
// positions, query FSM encoding and the ALU-op class test.
package registro_indicadores_pkg;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_MI = 4'd4;
  localparam logic [3:0] COND_PL = 4'd5;
  localparam logic [3:0] COND_VS = 4'd6;
  localparam logic [3:0] COND_VC = 4'd7;
  localparam logic [3:0] COND_HI = 4'd8;
  localparam logic [3:0] COND_LS = 4'd9;
  localparam logic [3:0] COND_GE = 4'd10;
  localparam logic [3:0] COND_LT = 4'd11;
  localparam logic [3:0] COND_GT = 4'd12;
  localparam logic [3:0] COND_LE = 4'd13;
  localparam logic [3:0] COND_AL = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  // ALUControl[ALU_CLASS_BIT] == ALU_CLASS_ARITH marks the add/sub class
  localparam int   ALU_CLASS_BIT   = 1;
  localparam logic ALU_CLASS_ARITH = 1'b0;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESULT = 1'b1
  } state_t;

endpackage

// File: rtl/registro_indicadores_evaluador_condicion.sv
// Combinational condition-code evaluator over a {N,Z,C,V} flag vector;
// kept standalone so a branch unit can reuse it.
module evaluador_condicion
  import registro_indicadores_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken_next
);

  logic n, z, c, v;

  always_comb begin
    n = flags[FLAG_N];
    z = flags[FLAG_Z];
    c = flags[FLAG_C];
    v = flags[FLAG_V];
    taken_next = 1'b0;
    case (cond)
      COND_EQ: taken_next = z;
      COND_NE: taken_next = !z;
      COND_CS: taken_next = c;
      COND_CC: taken_next = !c;
      COND_MI: taken_next = n;
      COND_PL: taken_next = !n;
      COND_VS: taken_next = v;
      COND_VC: taken_next = !v;
      COND_HI: taken_next = c & !z;
      COND_LS: taken_next = !c | z;
      COND_GE: taken_next = (n == v);
      COND_LT: taken_next = (n != v);
      COND_GT: taken_next = !z & (n == v);
      COND_LE: taken_next = z | (n != v);
      COND_AL: taken_next = 1'b1;
      COND_NV: taken_next = 1'b0;
      default: taken_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/registro_indicadores.sv
// Architectural {N,Z,C,V} status register with sticky overflow, saturating
// overflow-event counter and a valid/ready condition-query port.
//
// state     | meaning
// ST_IDLE   | no result held; any query is accepted
// ST_RESULT | result on taken/res_valid; new query accepted only with res_ready
module registro_indicadores
  import registro_indicadores_pkg::*;
#(
  parameter int         CNT_W       = 8,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flag_we,
  input  logic [2:0]       ALUControl,
  input  logic             Negative,
  input  logic             Zero,
  input  logic             Carry,
  input  logic             Overflow,
  input  logic             clr_sticky,
  input  logic             cond_valid,
  input  logic [3:0]       cond,
  output logic             cond_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             taken,
  output logic [3:0]       flags,
  output logic             sticky_v,
  output logic [CNT_W-1:0] ovf_count
);

  state_t     state, state_next;
  logic [3:0] flags_next;
  logic       alu_arith;
  logic       ovf_event;
  logic       accept;
  logic       taken_next;
  logic       unused_alu;

  assign unused_alu = ^{ALUControl[2], ALUControl[0]};
  assign alu_arith  = (ALUControl[ALU_CLASS_BIT] == ALU_CLASS_ARITH);
  assign ovf_event  = flag_we & alu_arith & Overflow;

  always_comb begin
    flags_next = flags;
    if (flag_we) begin
      flags_next[FLAG_N] = Negative;
      flags_next[FLAG_Z] = Zero;
      if (alu_arith) begin
        flags_next[FLAG_C] = Carry;
        flags_next[FLAG_V] = Overflow;
      end
    end
  end

  // Evaluate against this cycle's captured flags so compare->branch has no bubble
  evaluador_condicion u_eval (
    .cond       (cond),
    .flags      (flags_next),
    .taken_next (taken_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      flags     <= RESET_FLAGS;
      sticky_v  <= 1'b0;
      ovf_count <= '0;
    end else begin
      flags <= flags_next;
      if (clr_sticky) begin
        sticky_v  <= 1'b0;
        ovf_count <= '0;
      end else if (ovf_event) begin
        sticky_v <= 1'b1;
        if (ovf_count != {CNT_W{1'b1}})
          ovf_count <= ovf_count + CNT_W'(1);
      end
    end
  end

  assign cond_ready = (state == ST_IDLE) || res_ready;
  assign accept     = cond_valid && cond_ready;
  assign res_valid  = (state == ST_RESULT);

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cond_valid) state_next = ST_RESULT;
      ST_RESULT: if (res_ready && !cond_valid) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      taken <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) taken <= taken_next;
    end
  end

endmodule

// File: tb/tb_registro_indicadores.sv
// Directed-vector bench for registro_indicadores (counter narrowed to 2 bits
// so saturation is reachable in a few captures).
module tb_registro_indicadores;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic [2:0] ALUControl;
  logic       Negative, Zero, Carry, Overflow;
  logic       clr_sticky;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       res_valid;
  logic       res_ready;
  logic       taken;
  logic [3:0] flags;
  logic       sticky_v;
  logic [1:0] ovf_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  registro_indicadores #(.CNT_W(2), .RESET_FLAGS(4'b0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .flag_we    (flag_we),
    .ALUControl (ALUControl),
    .Negative   (Negative),
    .Zero       (Zero),
    .Carry      (Carry),
    .Overflow   (Overflow),
    .clr_sticky (clr_sticky),
    .cond_valid (cond_valid),
    .cond       (cond),
    .cond_ready (cond_ready),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .taken      (taken),
    .flags      (flags),
    .sticky_v   (sticky_v),
    .ovf_count  (ovf_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one edge; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input logic [2:0] op, input logic [3:0] nzcv);
    flag_we = 1'b1;
    ALUControl = op;
    {Negative, Zero, Carry, Overflow} = nzcv;
  endtask

  logic [15:0] exp_a;
  logic [15:0] exp_b;

  initial begin
    rst = 1'b1; flag_we = 1'b0; ALUControl = 3'b000;
    {Negative, Zero, Carry, Overflow} = 4'b0000;
    clr_sticky = 1'b0; cond_valid = 1'b0; cond = 4'd0; res_ready = 1'b1;
    exp_a = 16'h6996;  // flags 1010
    exp_b = 16'h6A69;  // flags 0101

    step(); step();
    rst = 1'b0;
    step();
    chk("rst_flags", flags, 4'b0000);
    chk("rst_sticky", sticky_v, 1'b0);
    chk("rst_count", ovf_count, 2'd0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_taken", taken, 1'b0);
    chk("rst_cond_ready", cond_ready, 1'b1);

    // capture then EQ query; then back-to-back HI query
    capture(3'b000, 4'b0110);
    step();
    flag_we = 1'b0;
    chk("cap_flags", flags, 4'b0110);
    cond_valid = 1'b1; cond = 4'd0;
    step();
    chk("eq_valid", res_valid, 1'b1);
    chk("eq_taken", taken, 1'b1);
    cond = 4'd8;
    step();
    chk("hi_valid", res_valid, 1'b1);
    chk("hi_taken", taken, 1'b0);
    cond_valid = 1'b0;
    step();
    chk("idle_res_valid", res_valid, 1'b0);

    // logic ops leave C/V and the counter alone
    capture(3'b000, 4'b0011);
    step();
    chk("cv_set_flags", flags, 4'b0011);
    chk("cv_set_count", ovf_count, 2'd1);
    chk("cv_set_sticky", sticky_v, 1'b1);
    capture(3'b010, 4'b1000);
    step();
    chk("logic_flags", flags, 4'b1011);
    capture(3'b110, 4'b0101);
    step();
    flag_we = 1'b0;
    chk("logic_v_flags", flags, 4'b0111);
    chk("logic_v_count", ovf_count, 2'd1);

    // saturation
    for (int i = 0; i < 5; i++) begin
      capture(3'b001, 4'b0001);
      step();
    end
    flag_we = 1'b0;
    chk("sat_count", ovf_count, 2'd3);
    chk("sat_sticky", sticky_v, 1'b1);
    clr_sticky = 1'b1;
    capture(3'b000, 4'b0001);
    step();
    clr_sticky = 1'b0; flag_we = 1'b0;
    chk("clr_count", ovf_count, 2'd0);
    chk("clr_sticky", sticky_v, 1'b0);
    chk("clr_flags", flags, 4'b0001);

    // backpressure: flags N=0 V=1, GE=0 then LT=1
    cond_valid = 1'b1; cond = 4'd10; res_ready = 1'b0;
    step();
    chk("ge_taken", taken, 1'b0);
    cond = 4'd11;
    for (int i = 0; i < 3; i++) begin
      chk("stall_ready", cond_ready, 1'b0);
      step();
      chk("stall_taken", taken, 1'b0);
      chk("stall_valid", res_valid, 1'b1);
    end
    res_ready = 1'b1;
    #1;
    chk("release_ready", cond_ready, 1'b1);
    step();
    chk("release_taken", taken, 1'b1);
    chk("release_valid", res_valid, 1'b1);
    cond_valid = 1'b0;
    step();
    chk("bp_idle", res_valid, 1'b0);

    // full condition table, back-to-back queries
    capture(3'b000, 4'b1010);
    step();
    flag_we = 1'b0;
    cond_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      step();
      chk($sformatf("tab_a_c%0d", i), taken, exp_a[i]);
    end
    cond_valid = 1'b0;
    capture(3'b000, 4'b0101);
    step();
    flag_we = 1'b0;
    cond_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      cond = 4'(i);
      step();
      chk($sformatf("tab_b_c%0d", i), taken, exp_b[i]);
    end
    cond_valid = 1'b0;

    // forwarding: old flags 0000 (LT=0), captured N=1 V=0 (LT=1)
    capture(3'b000, 4'b0000);
    step();
    capture(3'b000, 4'b1000);
    cond_valid = 1'b1; cond = 4'd11;
    step();
    flag_we = 1'b0; cond_valid = 1'b0;
    chk("fwd_taken", taken, 1'b1);
    chk("fwd_valid", res_valid, 1'b1);
    chk("fwd_flags", flags, 4'b1000);

    // reset mid-result
    res_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_mid_valid", res_valid, 1'b0);
    chk("rst_mid_taken", taken, 1'b0);
    chk("rst_mid_flags", flags, 4'b0000);
    chk("rst_mid_ready", cond_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
